out_regs_sequencer: RTL and testbench
=====================================

OUT_REGS_SEQUENCER -- requirements
Module: out_regs_sequencer

Interface
REQ-001 Parameters: none; the block SHALL have exactly 16 channels and 8-bit data.
REQ-002 CLK  input  1  single clock for all state; all outputs are registered on its rising edge.
REQ-003 CLR  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_op  input  2  00 write register, 01 set output enable, 10 clear output enable, 11 soft-clear all registers.
REQ-007 cmd_addr  input  4  channel index 0..15.
REQ-008 cmd_data  input  8  write data; ignored for ops 01/10/11.
REQ-009 reg_data  output  8  shared data bus to the 16 output registers.
REQ-010 reg_sel  output  16  one-hot per-channel load strobe; register loads on its rising edge.
REQ-011 reg_clr  output  1  clear to all output registers.
REQ-012 dir_en  output  16  per-channel output-buffer enable.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, STROBE, HOLD and CLRP; cmd_ready SHALL equal (state==IDLE) and CLR low.
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_op/addr/data SHALL be captured on that edge.
REQ-016 Write (op 00) accepted at edge T: SETUP in cycle after T (reg_data=captured data, reg_sel=0); STROBE next cycle (reg_sel[addr]=1 only); HOLD next cycle (reg_sel=0, reg_data unchanged); IDLE next cycle.
REQ-017 A write SHALL therefore occupy 4 cycles; back-to-back writes SHALL give one accepted command every 4 cycles.
REQ-018 reg_data SHALL be stable for the full SETUP, STROBE and HOLD cycles; it holds its last value in IDLE.
REQ-019 reg_sel SHALL never have more than one bit set, and SHALL be all-zero outside STROBE.
REQ-020 Op 01/10 SHALL set/clear dir_en[addr] on the accepting edge, leave every other dir_en bit unchanged, and keep state IDLE (one command per cycle sustained).
REQ-021 Op 11 SHALL enter CLRP for exactly 2 cycles with reg_clr=1, then return to IDLE; dir_en SHALL be unchanged by op 11.
REQ-022 reg_clr SHALL be 0 in every state other than CLRP.
REQ-023 cmd_valid while busy SHALL be ignored (no capture); the requester holds the command until accepted.

Reset
REQ-024 CLR high at a rising edge SHALL force state IDLE, reg_data=0, reg_sel=0, reg_clr=0, dir_en=0 and busy=0 on that edge, from any state.
REQ-025 CLR asserted mid-write or mid-clear SHALL abort it; no reg_sel pulse SHALL be emitted after the CLR edge.
REQ-026 While CLR is high, cmd_ready SHALL be 0 and no command SHALL be accepted.

Configuration
REQ-027 Macro OUT_SEQ_SHADOW_EN defined: add ports rd_addr (input 4) and rd_data (output 8); keep a 16x8 shadow array holding the last value written per channel.
REQ-028 With OUT_SEQ_SHADOW_EN, a shadow entry SHALL update on the edge that ends STROBE; op 11 and CLR SHALL zero all entries; rd_data SHALL equal shadow[rd_addr] combinationally.
REQ-029 Without OUT_SEQ_SHADOW_EN, rd_addr, rd_data and the shadow array SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset, then write op00 addr 5 data 0xA5 -> reg_data=0xA5 for 3 cycles, reg_sel=0x0020 for exactly 1 cycle (the middle one), cmd_ready back to 1 four cycles after acceptance.
REQ-031 cmd_valid held high with op00 to addrs 0,15,7 -> exactly one strobe each on bits 0, 15, 7 in order, 4 cycles apart, no overlap.
REQ-032 op01 addr 3, op01 addr 12, op10 addr 3 on consecutive cycles -> dir_en 0x0008, then 0x1008, then 0x1000; busy stays 0.
REQ-033 op11 with dir_en=0x00FF -> reg_clr=1 for exactly 2 cycles, busy=1 for those cycles, dir_en still 0x00FF afterwards.
REQ-034 CLR asserted during SETUP of a write to addr 9 -> no reg_sel pulse ever appears; all outputs 0 on the next cycle.
REQ-035 With OUT_SEQ_SHADOW_EN: write 0x3C to addr 2, then rd_addr=2 -> rd_data=0x3C; after op11 -> rd_data=0x00.

Source files
------------

// File: rtl/out_regs_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : out_regs_sequencer
// Purpose : Sequences commands onto 16 8-bit output registers and their
//           per-channel output enables. Optional shadow readback when
//           OUT_SEQ_SHADOW_EN is defined.
// Rev     : 1.0
// ============================================================================
module out_regs_sequencer (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic [7:0]  reg_data,
    output logic [15:0] reg_sel,
    output logic        reg_clr,
    output logic [15:0] dir_en,
    output logic        busy
`ifdef OUT_SEQ_SHADOW_EN
    ,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        CLRP   = 3'd4
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SET_EN = 2'b01;
    localparam logic [1:0] OP_CLR_EN = 2'b10;
    localparam logic [1:0] OP_SCLR   = 2'b11;

    state_t     state;
    logic [3:0] addr_q;
    logic       clr_second;

    assign cmd_ready = (state == IDLE) && !CLR;
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state      <= IDLE;
            addr_q     <= 4'd0;
            clr_second <= 1'b0;
            reg_data   <= 8'd0;
            reg_sel    <= 16'd0;
            reg_clr    <= 1'b0;
            dir_en     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                reg_data <= cmd_data;
                                addr_q   <= cmd_addr;
                                state    <= SETUP;
                            end
                            OP_SET_EN: dir_en[cmd_addr] <= 1'b1;
                            OP_CLR_EN: dir_en[cmd_addr] <= 1'b0;
                            OP_SCLR: begin
                                reg_clr    <= 1'b1;
                                clr_second <= 1'b0;
                                state      <= CLRP;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                SETUP: begin
                    reg_sel <= 16'h0001 << addr_q;
                    state   <= STROBE;
                end
                STROBE: begin
                    reg_sel <= 16'd0;
                    state   <= HOLD;
                end
                HOLD: state <= IDLE;
                // Two-cycle clear pulse: the flag marks the second cycle.
                CLRP: begin
                    if (clr_second) begin
                        reg_clr    <= 1'b0;
                        clr_second <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        clr_second <= 1'b1;
                    end
                end
                default: begin
                    reg_sel <= 16'd0;
                    reg_clr <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef OUT_SEQ_SHADOW_EN
    logic [7:0] shadow [16];

    always_ff @(posedge CLK) begin
        if (CLR || (state == IDLE && cmd_valid && cmd_op == OP_SCLR)) begin
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= 8'd0;
            end
        end else if (state == STROBE) begin
            shadow[addr_q] <= reg_data;
        end
    end

    assign rd_data = shadow[rd_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_out_regs_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_out_regs_sequencer
// Purpose : Self-checking bench with directed scenarios and a randomized run
//           against a transaction-level reference model.
// Rev     : 1.0
// ============================================================================
module tb_out_regs_sequencer;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [3:0]  cmd_addr = 4'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic [7:0]  reg_data;
    logic [15:0] reg_sel;
    logic        reg_clr;
    logic [15:0] dir_en;
    logic        busy;
`ifdef OUT_SEQ_SHADOW_EN
    logic [3:0]  rd_addr = 4'd0;
    logic [7:0]  rd_data;
`endif

    int checks = 0;
    int errors = 0;

    out_regs_sequencer dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .reg_data  (reg_data),
        .reg_sel   (reg_sel),
        .reg_clr   (reg_clr),
        .dir_en    (dir_en),
        .busy      (busy)
`ifdef OUT_SEQ_SHADOW_EN
        ,
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: an accepted operation reserves a number of busy
    // cycles; m_pos says which cycle of that operation we are in.
    int         m_cnt;
    int         m_pos;
    bit         m_is_write;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic [15:0] m_dir;
    logic [7:0] m_shadow [16];

    function automatic logic [15:0] exp_sel();
        if (m_cnt > 0 && m_is_write && m_pos == 2) return 16'(1 << m_addr);
        return 16'd0;
    endfunction

    task automatic model_step();
        if (CLR) begin
            m_cnt = 0; m_pos = 0; m_is_write = 0; m_data = 0; m_dir = 0;
            for (int i = 0; i < 16; i++) m_shadow[i] = 0;
        end else if (m_cnt > 0) begin
            if (m_is_write && m_pos == 2) m_shadow[m_addr] = m_data;
            m_cnt--; m_pos++;
        end else if (cmd_valid) begin
            case (cmd_op)
                2'b00: begin
                    m_cnt = 3; m_pos = 1; m_is_write = 1;
                    m_addr = cmd_addr; m_data = cmd_data;
                end
                2'b01: m_dir = m_dir | 16'(1 << cmd_addr);
                2'b10: m_dir = m_dir & ~16'(1 << cmd_addr);
                default: begin
                    m_cnt = 2; m_pos = 1; m_is_write = 0;
                    for (int i = 0; i < 16; i++) m_shadow[i] = 0;
                end
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 0; CLR = 1;
        tick();
        CLR = 0;
        #1;
    endtask

    task automatic test_reset();
        CLR = 1; cmd_valid = 1; cmd_op = 2'b00; cmd_addr = 4'd3; cmd_data = 8'h77;
        tick(); tick();
        checks++;
        if ({reg_data, reg_sel, reg_clr, dir_en, busy, cmd_ready} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h sel=%h clr=%b dir=%h busy=%b rdy=%b want all 0",
                     reg_data, reg_sel, reg_clr, dir_en, busy, cmd_ready);
        end
        cmd_valid = 0; CLR = 0; #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        logic [7:0]  want_data [4] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
        logic [15:0] want_sel  [4] = '{16'h0000, 16'h0020, 16'h0000, 16'h0000};
        logic        want_rdy  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        cmd_valid = 1; cmd_op = 2'b00; cmd_addr = 4'd5; cmd_data = 8'hA5;
        tick();
        cmd_valid = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (reg_data !== want_data[k] || reg_sel !== want_sel[k] || cmd_ready !== want_rdy[k]
                || busy !== !want_rdy[k]) begin
                errors++;
                $display("FAIL write_basic cyc%0d got data=%h sel=%h rdy=%b busy=%b want data=%h sel=%h rdy=%b",
                         k + 1, reg_data, reg_sel, cmd_ready, busy, want_data[k], want_sel[k], want_rdy[k]);
            end
            if (k < 3) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] addrs [3] = '{4'd0, 4'd15, 4'd7};
        int idx = 0;
        int strobe_cyc [$];
        int strobe_bit [$];
        bit acc;
        do_reset();
        cmd_valid = 1; cmd_op = 2'b00; cmd_addr = addrs[0]; cmd_data = 8'h11;
        for (int c = 0; c < 20; c++) begin
            acc = cmd_valid && (m_cnt == 0);
            tick();
            if (reg_sel != 0) begin
                strobe_cyc.push_back(c);
                for (int b = 0; b < 16; b++) if (reg_sel[b]) strobe_bit.push_back(b);
            end
            checks++;
            if (!$onehot0(reg_sel)) begin
                errors++; $display("FAIL b2b_onehot got sel=%h want at most one bit", reg_sel);
            end
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    cmd_addr = addrs[idx]; cmd_data = cmd_data + 8'h11;
                end else cmd_valid = 0;
            end
        end
        checks++;
        if (strobe_bit.size() != 3) begin
            errors++; $display("FAIL b2b_count got %0d strobes want 3", strobe_bit.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (strobe_bit[i] != int'(addrs[i]) || (i > 0 && strobe_cyc[i] - strobe_cyc[i-1] != 4)) begin
                    errors++;
                    $display("FAIL b2b_order strobe%0d got bit %0d gap %0d want bit %0d gap 4",
                             i, strobe_bit[i], (i > 0) ? strobe_cyc[i] - strobe_cyc[i-1] : 4, addrs[i]);
                end
            end
        end
    endtask

    task automatic test_dir_enable();
        logic [1:0]  ops  [3] = '{2'b01, 2'b01, 2'b10};
        logic [3:0]  adrs [3] = '{4'd3, 4'd12, 4'd3};
        logic [15:0] want [3] = '{16'h0008, 16'h1008, 16'h1000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1; cmd_op = ops[i]; cmd_addr = adrs[i]; cmd_data = 8'($urandom);
            tick();
            checks++;
            if (dir_en !== want[i] || busy !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir_enable step%0d got dir=%h busy=%b rdy=%b want dir=%h busy=0 rdy=1",
                         i, dir_en, busy, cmd_ready, want[i]);
            end
        end
        cmd_valid = 0;
    endtask

    task automatic test_soft_clear();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1; cmd_op = 2'b01; cmd_addr = 4'(i);
            tick();
        end
        cmd_op = 2'b11;
        tick();
        cmd_valid = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (reg_clr !== (k < 2) || busy !== (k < 2) || dir_en !== 16'h00FF || reg_sel !== 16'h0) begin
                errors++;
                $display("FAIL soft_clear cyc%0d got clr=%b busy=%b dir=%h sel=%h want clr=%b busy=%b dir=00ff sel=0",
                         k, reg_clr, busy, dir_en, reg_sel, k < 2, k < 2);
            end
            if (k < 2) tick();
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        do_reset();
        cmd_valid = 1; cmd_op = 2'b00; cmd_addr = 4'd9; cmd_data = 8'h5A;
        tick();
        cmd_valid = 0; CLR = 1;
        tick();
        checks++;
        if ({reg_data, reg_sel, reg_clr, dir_en, busy} !== 41'd0) begin
            errors++;
            $display("FAIL abort_outputs got data=%h sel=%h clr=%b dir=%h busy=%b want all 0",
                     reg_data, reg_sel, reg_clr, dir_en, busy);
        end
        CLR = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (reg_sel != 0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_no_strobe got a reg_sel pulse want none");
        end
    endtask

    task automatic test_random();
        bit holding = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            CLR = ($urandom_range(0, 39) == 0);
            if (!holding && $urandom_range(0, 2) != 0) begin
                holding = 1; cmd_valid = 1;
                cmd_op = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
                cmd_addr = 4'($urandom); cmd_data = 8'($urandom);
            end
`ifdef OUT_SEQ_SHADOW_EN
            rd_addr = 4'($urandom);
`endif
            if (holding && m_cnt == 0 && !CLR) holding = 0;
            tick();
            if (!holding) cmd_valid = 0;
            #1;
            checks++;
            if (reg_data !== m_data || reg_sel !== exp_sel() || reg_clr !== (m_cnt > 0 && !m_is_write)
                || dir_en !== m_dir || busy !== (m_cnt > 0) || cmd_ready !== (m_cnt == 0 && !CLR)) begin
                errors++;
                $display("FAIL random cyc%0d got data=%h sel=%h clr=%b dir=%h busy=%b rdy=%b want data=%h sel=%h clr=%b dir=%h busy=%b",
                         c, reg_data, reg_sel, reg_clr, dir_en, busy, cmd_ready,
                         m_data, exp_sel(), m_cnt > 0 && !m_is_write, m_dir, m_cnt > 0);
            end
`ifdef OUT_SEQ_SHADOW_EN
            checks++;
            if (rd_data !== m_shadow[rd_addr]) begin
                errors++;
                $display("FAIL random_shadow addr %0d got %h want %h", rd_addr, rd_data, m_shadow[rd_addr]);
            end
`endif
        end
        cmd_valid = 0; CLR = 0;
    endtask

`ifdef OUT_SEQ_SHADOW_EN
    task automatic test_shadow();
        do_reset();
        cmd_valid = 1; cmd_op = 2'b00; cmd_addr = 4'd2; cmd_data = 8'h3C;
        tick();
        cmd_valid = 0;
        tick(); tick(); tick();
        rd_addr = 4'd2; #1;
        checks++;
        if (rd_data !== 8'h3C) begin
            errors++; $display("FAIL shadow_read got %h want 3c", rd_data);
        end
        cmd_valid = 1; cmd_op = 2'b11;
        tick();
        cmd_valid = 0;
        tick(); tick();
        checks++;
        if (rd_data !== 8'h00) begin
            errors++; $display("FAIL shadow_clear got %h want 00", rd_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_back_to_back();
        test_dir_enable();
        test_soft_clear();
        test_abort();
`ifdef OUT_SEQ_SHADOW_EN
        test_shadow();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
